// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch/decode pipeline stage register.
package pipe_pkg;

  // Default payload width: one full fetch/decode bundle.
  localparam int unsigned BUNDLE_W = 81;

  // Bit offsets of the fetch/decode bundle fields.
  localparam int unsigned NEXT_ADDR_LSB = 0;
  localparam int unsigned NEXT_ADDR_MSB = 31;
  localparam int unsigned OPCODE_LSB    = 32;
  localparam int unsigned OPCODE_MSB    = 36;
  localparam int unsigned RS_LSB        = 37;
  localparam int unsigned RS_MSB        = 39;
  localparam int unsigned RD_LSB        = 40;
  localparam int unsigned RD_MSB        = 42;
  localparam int unsigned SHMNT_LSB     = 43;
  localparam int unsigned SHMNT_MSB     = 47;
  localparam int unsigned PC_LSB        = 48;
  localparam int unsigned PC_MSB        = 79;
  localparam int unsigned INT1_BIT      = 80;

  localparam int unsigned OCC_W       = 2;
  localparam int unsigned STALL_CNT_W = 16;

  // Stage occupancy state; the encoding equals the number of held payloads.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer.
// Optional feature: define PIPE_STAGE_STALL_CNT_EN to add the stall_cnt output,
// a saturating count of cycles where out_valid && !out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = BUNDLE_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  stage_state_e      state_q;
  stage_state_e      state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              load_main;
  logic              main_from_skid;
  logic              load_skid;

  // State register; reset dominates flush and every transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and data-load decisions; flush clears only the valid state.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_valid && out_ready) begin
          load_main = 1'b1;
        end else if (in_valid) begin
          // Without a skid entry the stage holds and upstream is stalled.
          if (SKID != 0) begin
            load_skid = 1'b1;
            state_d   = TWO;
          end
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_ready) begin
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d        = EMPTY;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Payload registers; main always feeds the output, skid catches overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  // Upstream ready: state-only with a skid entry, pass-through of out_ready without.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (SKID != 0) begin
        in_ready = (state_q != TWO);
      end else begin
        in_ready = (state_q == EMPTY) || out_ready;
      end
    end
  end

  // Output decode from the state register.
  always_comb begin
    out_valid = (state_q != EMPTY);
    out_data  = main_q;
    case (state_q)
      ONE:     occupancy = OCC_W'(1);
      TWO:     occupancy = OCC_W'(2);
      default: occupancy = OCC_W'(0);
    endcase
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Saturating stall counter; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule
